move_reader: RTL

- Consumer end of the move generator's position-RAM read interface.
- Waits for moves_ready, then walks move_index from 0 to move_count-1 and captures each returned position.
- Scores each position by material (white minus black) and keeps the best one for the side that moved; presents the best position with a valid/ack handshake.
- Then pulses clear_moves to release the generator. Sits between the move generator and the search/host control logic.

---
 rtl/vchess_eval_pkg.sv | 56 +++++
 rtl/move_reader_if.sv | 26 ++
 rtl/move_reader_row_material.sv | 29 ++
 rtl/move_reader.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vchess_eval_pkg.sv
// Shared evaluation constants and the move_reader state encoding.
// Board-encoding macros normally arrive from vchess.vh; the guarded defaults keep this slice standalone.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 64
`endif
`ifndef BLACK_BIT
`define BLACK_BIT 3
`endif
`ifndef PIECE_EMPTY
`define PIECE_EMPTY 0
`define PIECE_PAWN 1
`define PIECE_KNIGHT 2
`define PIECE_BISHOP 3
`define PIECE_ROOK 4
`define PIECE_QUEEN 5
`define PIECE_KING 6
`endif

package vchess_eval_pkg;

    localparam int SCORE_WIDTH_DEFAULT = 16;

    localparam int PAWN_VALUE   = 100;
    localparam int KNIGHT_VALUE = 300;
    localparam int BISHOP_VALUE = 300;
    localparam int ROOK_VALUE   = 500;
    localparam int QUEEN_VALUE  = 900;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LATCH,
        ST_SCORE,
        ST_COMPARE,
        ST_RESULT,
        ST_CLEAR,
        ST_DRAIN
    } move_reader_state_t;

    // Kings and empty squares carry no material, so they fall to the default.
    function automatic int piece_value(input int ptype);
        case (ptype)
            `PIECE_PAWN:   return PAWN_VALUE;
            `PIECE_KNIGHT: return KNIGHT_VALUE;
            `PIECE_BISHOP: return BISHOP_VALUE;
            `PIECE_ROOK:   return ROOK_VALUE;
            `PIECE_QUEEN:  return QUEEN_VALUE;
            default:       return 0;
        endcase
    endfunction

endpackage

// File: rtl/move_reader_if.sv
// Position-RAM read bus between the move generator (slave) and move_reader (master).
interface move_reader_if #(
    parameter int BOARD_WIDTH = `PIECE_BITS * 64,
    parameter int INDEX_WIDTH = $clog2(`MAX_POSITIONS)
);
    logic                   moves_ready;
    logic [INDEX_WIDTH-1:0] move_count;
    logic [INDEX_WIDTH-1:0] move_index;
    logic                   clear_moves;
    logic [BOARD_WIDTH-1:0] board_in;
    logic                   white_to_move_in;
    logic [3:0]             castle_mask_in;
    logic [3:0]             en_passant_col_in;

    modport master (
        input  moves_ready, move_count, board_in, white_to_move_in,
               castle_mask_in, en_passant_col_in,
        output move_index, clear_moves
    );

    modport slave (
        output moves_ready, move_count, board_in, white_to_move_in,
               castle_mask_in, en_passant_col_in,
        input  move_index, clear_moves
    );
endinterface

// File: rtl/move_reader_row_material.sv
// Combinational signed material sum of one board row: white pieces add, black pieces subtract.
module row_material
    import vchess_eval_pkg::*;
#(
    parameter int PIECE_WIDTH = `PIECE_BITS,
    parameter int SCORE_WIDTH = SCORE_WIDTH_DEFAULT
) (
    input  logic        [PIECE_WIDTH*8-1:0] row,
    output logic signed [SCORE_WIDTH-1:0]   material
);

    logic        [PIECE_WIDTH-1:0] piece;
    logic signed [SCORE_WIDTH-1:0] value;

    always_comb begin
        material = '0;
        piece    = '0;
        value    = '0;
        for (int col = 0; col < 8; col++) begin
            piece = row[col*PIECE_WIDTH +: PIECE_WIDTH];
            value = SCORE_WIDTH'(piece_value(int'(piece[PIECE_WIDTH-2:0])));
            if (piece[`BLACK_BIT])
                material = material - value;
            else
                material = material + value;
        end
    end

endmodule

// File: rtl/move_reader.sv
// Scans the generator's position RAM, keeps the materially best position for the mover, then releases the generator.
// Optional scan-cycle statistics are built when MOVE_READER_STATS_EN is defined.
module move_reader
    import vchess_eval_pkg::*;
#(
    parameter int PIECE_WIDTH        = `PIECE_BITS,
    parameter int SIDE_WIDTH         = PIECE_WIDTH * 8,
    parameter int BOARD_WIDTH        = SIDE_WIDTH * 8,
    parameter int MAX_POSITIONS      = `MAX_POSITIONS,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
    parameter int SCORE_WIDTH        = SCORE_WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    move_reader_if.master                 gen,
    output logic                          result_valid,
    input  logic                          result_ack,
    output logic                          no_moves,
    output logic [MAX_POSITIONS_LOG2-1:0] best_index,
    output logic signed [SCORE_WIDTH-1:0] best_score,
    output logic [BOARD_WIDTH-1:0]        best_board,
    output logic                          best_white_to_move,
    output logic [3:0]                    best_castle_mask,
    output logic [3:0]                    best_en_passant_col,
    output logic [31:0]                   scan_cycles
);

    move_reader_state_t state, next_state;

    logic [MAX_POSITIONS_LOG2-1:0] idx;
    logic [MAX_POSITIONS_LOG2-1:0] count_q;
    logic [BOARD_WIDTH-1:0]        board_q;
    logic                          white_to_move_q;
    logic [3:0]                    castle_mask_q;
    logic [3:0]                    en_passant_col_q;
    logic [2:0]                    row;
    logic signed [SCORE_WIDTH-1:0] acc;
    logic signed [SCORE_WIDTH-1:0] row_sum;
    logic                          last_move;
    logic                          better;

    row_material #(
        .PIECE_WIDTH (PIECE_WIDTH),
        .SCORE_WIDTH (SCORE_WIDTH)
    ) u_row_material (
        .row      (board_q[int'(row)*SIDE_WIDTH +: SIDE_WIDTH]),
        .material (row_sum)
    );

    assign gen.move_index  = idx;
    assign gen.clear_moves = (state == ST_CLEAR);
    assign result_valid    = (state == ST_RESULT);
    assign last_move       = (idx == count_q - MAX_POSITIONS_LOG2'(1));
    // The mover is the side NOT to move in the stored position; black wants the lowest score.
    assign better = white_to_move_q ? (acc < best_score) : (acc > best_score);

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (gen.moves_ready)
                            next_state = (gen.move_count == '0) ? ST_RESULT : ST_FETCH;
            ST_FETCH:   next_state = ST_WAIT;
            ST_WAIT:    next_state = ST_LATCH;
            ST_LATCH:   next_state = ST_SCORE;
            ST_SCORE:   if (row == 3'd7) next_state = ST_COMPARE;
            ST_COMPARE: next_state = last_move ? ST_RESULT : ST_FETCH;
            ST_RESULT:  if (result_ack) next_state = ST_CLEAR;
            ST_CLEAR:   next_state = ST_DRAIN;
            // Holding here until moves_ready drops stops us rescanning a stale RAM.
            ST_DRAIN:   if (!gen.moves_ready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx                 <= '0;
            count_q             <= '0;
            board_q             <= '0;
            white_to_move_q     <= 1'b0;
            castle_mask_q       <= '0;
            en_passant_col_q    <= '0;
            row                 <= '0;
            acc                 <= '0;
            no_moves            <= 1'b0;
            best_index          <= '0;
            best_score          <= '0;
            best_board          <= '0;
            best_white_to_move  <= 1'b0;
            best_castle_mask    <= '0;
            best_en_passant_col <= '0;
        end else begin
            case (state)
                ST_IDLE: if (gen.moves_ready) begin
                    count_q  <= gen.move_count;
                    idx      <= '0;
                    no_moves <= (gen.move_count == '0);
                    if (gen.move_count == '0) begin
                        best_index          <= '0;
                        best_score          <= '0;
                        best_board          <= '0;
                        best_white_to_move  <= 1'b0;
                        best_castle_mask    <= '0;
                        best_en_passant_col <= '0;
                    end
                end
                ST_LATCH: begin
                    board_q          <= gen.board_in;
                    white_to_move_q  <= gen.white_to_move_in;
                    castle_mask_q    <= gen.castle_mask_in;
                    en_passant_col_q <= gen.en_passant_col_in;
                    row              <= '0;
                    acc              <= '0;
                end
                ST_SCORE: begin
                    acc <= acc + row_sum;
                    row <= row + 3'd1;
                end
                ST_COMPARE: begin
                    if (idx == '0 || better) begin
                        best_index          <= idx;
                        best_score          <= acc;
                        best_board          <= board_q;
                        best_white_to_move  <= white_to_move_q;
                        best_castle_mask    <= castle_mask_q;
                        best_en_passant_col <= en_passant_col_q;
                    end
                    if (!last_move)
                        idx <= idx + MAX_POSITIONS_LOG2'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MOVE_READER_STATS_EN
    logic [31:0] cycle_count;

    // Starts at 1 so the IDLE-exit cycle is included in the count.
    always_ff @(posedge clk) begin
        if (reset)
            cycle_count <= '0;
        else if (state == ST_IDLE && gen.moves_ready)
            cycle_count <= 32'd1;
        else if (state inside {ST_FETCH, ST_WAIT, ST_LATCH, ST_SCORE, ST_COMPARE})
            cycle_count <= cycle_count + 32'd1;
    end

    assign scan_cycles = cycle_count;
`else
    assign scan_cycles = '0;
`endif

endmodule
